// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MFA/MFC memory access controller.
package mem_pkg;

  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDD  = 6'b000011;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STD  = 6'b000111;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_RELEASE, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE
  } size_e;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH, OP_LDD,
      OP_STB, OP_STH, OP_ST, OP_STD: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH, OP_LDD: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic size_e op_size(input logic [5:0] op);
    case (op)
      OP_LDSB, OP_LDUB, OP_STB: return SZ_BYTE;
      OP_LDSH, OP_LDUH, OP_STH: return SZ_HALF;
      OP_LDD, OP_STD:           return SZ_DOUBLE;
      default:                  return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [7:0] addr);
    case (sz)
      SZ_HALF:   return addr[0];
      SZ_WORD:   return |addr[1:0];
      SZ_DOUBLE: return |addr[2:0];
      default:   return 1'b0;
    endcase
  endfunction

  // Doubles are issued to the RAM as two plain word beats.
  function automatic logic [5:0] beat_opcode(input logic [5:0] op);
    if (op_size(op) == SZ_DOUBLE) return op_is_load(op) ? OP_LD : OP_ST;
    return op;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// RAM-side MFA/MFC bus between the controller and the data RAM.
interface mem_access_ctrl_if;
  logic        MFA;
  logic        MFC;
  logic [5:0]  opcode;
  logic [7:0]  address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output MFA, opcode, address, mem_wdata, input MFC, mem_rdata);
  modport slave  (input MFA, opcode, address, mem_wdata, output MFC, mem_rdata);
endinterface

// File: rtl/mem_access_ctrl_mfc_sync.sv
// Flop chain bringing the RAM's MFC into the clk domain.
module mfc_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  if (SYNC_STAGES == 0) begin : g_raw
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0] chain_q, chain_d;

    // Shift the raw MFC in at bit 0.
    always_comb begin
      chain_d    = chain_q << 1;
      chain_d[0] = d;
    end

    // Chain register, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain_q <= '0;
      else        chain_q <= chain_d;
    end

    assign q = chain_q[SYNC_STAGES-1];
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the SPARC data RAM MFA/MFC handshake.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [5:0]         op,
  input  logic [7:0]         addr,
  input  logic [31:0]        wdata,
  input  logic [31:0]        wdata2,
  output logic [31:0]        rdata,
  output logic [31:0]        rdata2,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err_code,
  mem_access_ctrl_if.master  ram
);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d, opcode_q, opcode_d;
  logic [7:0]  addr_q, addr_d, address_q, address_d, cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d, wdata2_q, wdata2_d, mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d, rdata2_q, rdata2_d;
  logic        second_q, second_d, mfa_q, mfa_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic        mfc_s;

  mfc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mfc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ram.MFC),
    .q     (mfc_s)
  );

  // Next-state and next-output logic; RAM-side bus values are loaded on the
  // transition into SETUP so they are already stable throughout SETUP.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wdata2_d    = wdata2_q;
    second_d    = second_q;
    cnt_d       = cnt_q;
    mfa_d       = mfa_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    opcode_d    = opcode_q;
    address_d   = address_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rdata2_d    = rdata2_q;
    unique case (state_q)
      ST_IDLE: if (req) begin
        op_d     = op;
        addr_d   = addr;
        wdata_d  = wdata;
        wdata2_d = wdata2;
        second_d = 1'b0;
        if (!op_legal(op)) begin
          err_d   = ERR_ILLEGAL;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (misaligned(op_size(op), addr)) begin
          err_d   = ERR_MISALIGN;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d      = 1'b1;
          opcode_d    = beat_opcode(op);
          address_d   = addr;
          mem_wdata_d = wdata;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        mfa_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (mfc_s) begin
          if (op_is_load(op_q)) begin
            if (second_q) rdata2_d = ram.mem_rdata;
            else          rdata_d  = ram.mem_rdata;
          end
          mfa_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          mfa_d   = 1'b0;
          busy_d  = 1'b0;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (!mfc_s) begin
          if (op_size(op_q) == SZ_DOUBLE && !second_q) begin
            second_d    = 1'b1;
            address_d   = addr_q + 8'd4;
            mem_wdata_d = wdata2_q;
            state_d     = ST_SETUP;
          end else begin
            busy_d  = 1'b0;
            err_d   = ERR_OK;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          busy_d  = 1'b0;
          err_d   = ERR_TIMEOUT;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops MFA immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wdata2_q    <= '0;
      second_q    <= 1'b0;
      cnt_q       <= '0;
      mfa_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
      opcode_q    <= '0;
      address_q   <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rdata2_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wdata2_q    <= wdata2_d;
      second_q    <= second_d;
      cnt_q       <= cnt_d;
      mfa_q       <= mfa_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      opcode_q    <= opcode_d;
      address_q   <= address_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rdata2_q    <= rdata2_d;
    end
  end

  assign ram.MFA       = mfa_q;
  assign ram.opcode    = opcode_q;
  assign ram.address   = address_q;
  assign ram.mem_wdata = mem_wdata_q;
  assign rdata         = rdata_q;
  assign rdata2        = rdata2_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_code      = err_q;
endmodule
